// File: rtl/gray_counter_pkg.sv
// Shared Gray-code helpers and defaults for the gray_counter block.
package gray_counter_pkg;

  localparam int GRAY_W_DEFAULT = 4;
  localparam int GRAY_W_MAX     = 16;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_LOAD,
    OP_CNT,
    OP_SAT
  } cnt_op_e;

  // Operates on a zero-extended max-width word; callers slice back to WIDTH.
  function automatic logic [GRAY_W_MAX-1:0] bin2gray(input logic [GRAY_W_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GRAY_W_MAX-1:0] gray2bin(input logic [GRAY_W_MAX-1:0] g);
    logic [GRAY_W_MAX-1:0] b;
    b[GRAY_W_MAX-1] = g[GRAY_W_MAX-1];
    for (int i = GRAY_W_MAX-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/gray_counter_encode_reg.sv
// Register pair holding bin and its Gray code, plus the per-update changed-bit mask.
module gray_encode_reg
  import gray_counter_pkg::*;
#(
  parameter int WIDTH = GRAY_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             upd_i,
  input  logic [WIDTH-1:0] bin_d_i,
  output logic [WIDTH-1:0] bin_o,
  output logic [WIDTH-1:0] gray_o,
  output logic [WIDTH-1:0] delta_o
);

  logic [WIDTH-1:0]      bin_q, gray_q, delta_q;
  logic [WIDTH-1:0]      gray_d;
  logic [GRAY_W_MAX-1:0] ext, enc;

  always_comb begin
    ext             = '0;
    ext[WIDTH-1:0]  = bin_d_i;
    enc             = bin2gray(ext);
    gray_d          = enc[WIDTH-1:0];
  end

  // Gray is encoded from the next binary value so both registers move together.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q   <= '0;
      gray_q  <= '0;
      delta_q <= '0;
    end else if (upd_i) begin
      bin_q   <= bin_d_i;
      gray_q  <= gray_d;
      delta_q <= gray_d ^ gray_q;
    end else begin
      delta_q <= '0;
    end
  end

  assign bin_o   = bin_q;
  assign gray_o  = gray_q;
  assign delta_o = delta_q;

endmodule

// File: rtl/gray_counter.sv
// Up/down binary counter with load, terminal count and registered Gray output.
module gray_counter
  import gray_counter_pkg::*;
#(
  parameter int WIDTH = GRAY_W_DEFAULT,
  parameter int WRAP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             tc,
  output logic [WIDTH-1:0] gray_delta
);

  cnt_op_e          op;
  logic             upd;
  logic [WIDTH-1:0] bin_d;

  assign tc = up ? (bin == {WIDTH{1'b1}}) : (bin == '0);

  always_comb begin
    op = OP_HOLD;
    if (load)    op = OP_LOAD;
    else if (en) op = ((WRAP == 0) && tc) ? OP_SAT : OP_CNT;
  end

  // Saturation and hold both leave the register pair untouched, clearing delta.
  always_comb begin
    bin_d = bin;
    upd   = 1'b0;
    case (op)
      OP_LOAD: begin
        bin_d = load_val;
        upd   = 1'b1;
      end
      OP_CNT: begin
        bin_d = up ? bin + 1'b1 : bin - 1'b1;
        upd   = 1'b1;
      end
      default: ;
    endcase
  end

  gray_encode_reg #(.WIDTH(WIDTH)) u_reg (
    .clk     (clk),
    .rst     (rst),
    .upd_i   (upd),
    .bin_d_i (bin_d),
    .bin_o   (bin),
    .gray_o  (gray),
    .delta_o (gray_delta)
  );

endmodule

// File: doc/gray_counter.md
Name: gray_counter

Overview:
- Sequential source stage that produces the binary count consumed by the binary-to-Gray converter, and also presents the registered Gray equivalent.
- Up/down counter with enable, synchronous load, terminal-count flag, and a per-step changed-bit mask (gray_delta) that exposes the single-bit-change property for checking.
- Sits directly upstream of the combinational binary-to-Gray block; its bin output drives that block's b input.

Parameters:
- WIDTH, 4, counter and code width in bits (legal 2..16).
- WRAP, 1, 1 = wrap at range ends; 0 = saturate at the end reached.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- en  input  1  count enable, sampled on the clk edge.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous load of load_val; has priority over en.
- load_val  input  WIDTH  binary value to load.
- bin  output  WIDTH  registered binary count.
- gray  output  WIDTH  registered Gray code of bin; gray = bin ^ (bin >> 1) at all times.
- tc  output  1  terminal count, combinational from bin and up: 1 when bin = 2^WIDTH-1 with up=1, or bin = 0 with up=0.
- gray_delta  output  WIDTH  registered gray_next ^ gray for the most recent update; 0 when the count did not change.

Behaviour:
- Reset: when rst=1 at a clk edge, bin=0, gray=0 and gray_delta=0. tc follows from bin=0 (it is 1 if up=0). rst overrides load and en. Mid-count reset returns the block to 0 on that edge.
- Priority per edge is rst > load > en > hold.
- Load: bin <= load_val and gray <= bin2gray(load_val), both in the same edge, with 1-cycle latency. gray_delta <= old gray ^ new gray, which may have several bits set.
- Count, en=1 and load=0:
  - up=1: bin <= bin+1, modulo 2^WIDTH.
  - up=0: bin <= bin-1, modulo 2^WIDTH.
  - gray updates in the same edge.
  - gray_delta is one-hot on every counting step, including the wrap steps 2^WIDTH-1 -> 0 and 0 -> 2^WIDTH-1.
- Saturation (WRAP=0): when tc=1 and en=1, bin holds and gray_delta <= 0.
- Hold: en=0 and load=0 leaves bin and gray unchanged and sets gray_delta <= 0.
- Direction change: a change of up takes effect on the same edge; there is no dead cycle.
- Width rules: all arithmetic is unsigned WIDTH-bit. No carry/borrow output; tc covers that role.
- Internal next-state logic: bin_next is computed first, gray_next = bin2gray(bin_next), and both registers update on the same edge. gray is never derived from the registered bin with a lag.
- Single clock domain; no asynchronous paths. Outputs are glitch-free registers, except tc.

Decomposition:
- Shared package holds:
  - bin2gray function, WIDTH-generic.
  - gray2bin function, used by the bench.
  - GRAY_W_DEFAULT = 4.
- One natural sub-module: gray_encode_reg, a WIDTH-bit register pair storing bin and gray together with the delta computation. The counter FSM instantiates it once.
- Next-state logic lives in the top.

Test Plan:
- Reset then up-count: rst=1 for 2 cycles, then en=1, up=1 for 16 cycles.
  - bin must run 0..15 and wrap to 0.
  - gray must follow 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8,0.
  - gray_delta must have popcount 1 on every step.
  - tc=1 exactly when bin=15.
- Down-count from reset: en=1, up=0.
  - bin must go 0 -> 15 -> 14, with gray 0 -> 8 -> 9.
  - tc=1 during the cycle with bin=0.
- Load priority: at bin=5, assert load=1, load_val=12 and en=1 together.
  - Next cycle bin=12, gray=10.
  - gray_delta = 7^10 = 13.
- Saturation with WRAP=0: load 15, then en=1, up=1 for 3 cycles.
  - bin stays 15, gray stays 8, gray_delta=0, tc=1.
  - Then set up=0: next cycle bin=14, gray=9.
- Reset mid-operation: counting up at bin=9, assert rst=1 together with load=1, load_val=3.
  - Next cycle bin=0, gray=0, gray_delta=0; the load is ignored.
- Hold: en=0 for 4 cycles at bin=6.
  - bin=6 and gray=5 are stable, gray_delta=0.
  - Bench checks bin == gray2bin(gray) every cycle of every scenario.
